// File: rtl/periph_amo_target.sv
// Peripheral req/gnt responder backed by a small flop word memory.
// Serves reads, byte-enabled writes and RISC-V AMOs with in-order responses.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   data_req_i           request valid
//   data_add_i           byte address
//   data_wen_i           1 = read, 0 = write (ignored for AMOs)
//   data_atop_i          [5] AMO enable, [4:0] RISC-V funct5
//   data_wdata_i         write data / AMO operand
//   data_be_i            byte enables
//   data_gnt_o           request accepted this cycle (combinational)
//   data_r_valid_o       single-cycle response pulse
//   data_r_opc_o         1 = error response
//   data_r_rdata_o       read data / AMO old value
module periph_amo_target #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int BYTE_ENABLE_BIT = DATA_WIDTH / 8,
   parameter int NUM_WORDS       = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       data_req_i,
   input  logic [ADDR_WIDTH-1:0]      data_add_i,
   input  logic                       data_wen_i,
   input  logic [5:0]                 data_atop_i,
   input  logic [DATA_WIDTH-1:0]      data_wdata_i,
   input  logic [BYTE_ENABLE_BIT-1:0] data_be_i,
   output logic                       data_gnt_o,
   output logic                       data_r_valid_o,
   output logic                       data_r_opc_o,
   output logic [DATA_WIDTH-1:0]      data_r_rdata_o
);

   localparam int BW = $clog2(BYTE_ENABLE_BIT);
   localparam int IW = $clog2(NUM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] SPAN =
      ADDR_WIDTH'(NUM_WORDS * BYTE_ENABLE_BIT);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] AMO_WB = 1'b1;

   localparam logic [4:0] F_ADD  = 5'b00000;
   localparam logic [4:0] F_SWAP = 5'b00001;
   localparam logic [4:0] F_XOR  = 5'b00100;
   localparam logic [4:0] F_AND  = 5'b01100;
   localparam logic [4:0] F_OR   = 5'b01000;
   localparam logic [4:0] F_MIN  = 5'b10000;
   localparam logic [4:0] F_MAX  = 5'b10100;
   localparam logic [4:0] F_MINU = 5'b11000;
   localparam logic [4:0] F_MAXU = 5'b11100;

   logic [0:0]            state;
   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

   logic [ADDR_WIDTH-1:0] offset;
   logic                  hit;
   logic [IW-1:0]         idx;
   logic                  is_amo;
   logic                  fn_ok;
   logic                  be_full;
   logic                  err;
   logic                  accept;

   logic [IW-1:0]         amo_idx;
   logic [4:0]            amo_fn;
   logic [DATA_WIDTH-1:0] amo_old;
   logic [DATA_WIDTH-1:0] amo_opnd;
   logic [DATA_WIDTH-1:0] amo_res;

   // Wrapping subtraction makes addresses below the base miss as well.
   assign offset  = data_add_i - BASE_ADDR;
   assign hit     = offset < SPAN;
   assign idx     = offset[BW +: IW];
   assign is_amo  = data_atop_i[5];
   assign be_full = &data_be_i;

   always_comb begin
      fn_ok = 1'b0;
      case (data_atop_i[4:0])
         F_ADD, F_SWAP, F_XOR, F_AND, F_OR,
         F_MIN, F_MAX, F_MINU, F_MAXU: fn_ok = 1'b1;
         default:                      fn_ok = 1'b0;
      endcase
   end

   assign err = ~hit | (is_amo & (~fn_ok | ~be_full));

   assign data_gnt_o = data_req_i & (state == IDLE);
   assign accept     = data_gnt_o;

   always_comb begin
      amo_res = amo_old;
      case (amo_fn)
         F_ADD:  amo_res = amo_old + amo_opnd;
         F_SWAP: amo_res = amo_opnd;
         F_XOR:  amo_res = amo_old ^ amo_opnd;
         F_AND:  amo_res = amo_old & amo_opnd;
         F_OR:   amo_res = amo_old | amo_opnd;
         F_MIN:  amo_res = ($signed(amo_old) < $signed(amo_opnd))
                           ? amo_old : amo_opnd;
         F_MAX:  amo_res = ($signed(amo_old) > $signed(amo_opnd))
                           ? amo_old : amo_opnd;
         F_MINU: amo_res = (amo_old < amo_opnd) ? amo_old : amo_opnd;
         F_MAXU: amo_res = (amo_old > amo_opnd) ? amo_old : amo_opnd;
         default: amo_res = amo_old;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state          <= IDLE;
         data_r_valid_o <= 1'b0;
         data_r_opc_o   <= 1'b0;
         data_r_rdata_o <= '0;
         amo_idx        <= '0;
         amo_fn         <= '0;
         amo_old        <= '0;
         amo_opnd       <= '0;
         for (int w = 0; w < NUM_WORDS; w++) begin
            mem[w] <= '0;
         end
      end else begin
         data_r_valid_o <= accept;
         data_r_opc_o   <= 1'b0;
         data_r_rdata_o <= '0;
         if (state == AMO_WB) begin
            // Write-back slot: no grant, response already on the bus.
            mem[amo_idx] <= amo_res;
            state        <= IDLE;
         end else if (accept) begin
            if (err) begin
               data_r_opc_o <= 1'b1;
            end else if (is_amo) begin
               // Old value goes out now; result commits next edge.
               data_r_rdata_o <= mem[idx];
               amo_old        <= mem[idx];
               amo_opnd       <= data_wdata_i;
               amo_fn         <= data_atop_i[4:0];
               amo_idx        <= idx;
               state          <= AMO_WB;
            end else if (data_wen_i) begin
               data_r_rdata_o <= mem[idx];
            end else begin
               for (int b = 0; b < BYTE_ENABLE_BIT; b++) begin
                  if (data_be_i[b]) begin
                     mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_periph_amo_target.sv
// Randomized self-checking bench for periph_amo_target.
// Reference model: word array plus AMO arithmetic evaluated per transaction.
module tb_periph_amo_target;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk;
   logic        rst;
   logic        req;
   logic [31:0] add;
   logic        wen;
   logic [5:0]  atop;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        gnt;
   logic        r_valid;
   logic        r_opc;
   logic [31:0] r_rdata;

   int nchk;
   int nerr;
   logic [31:0] ref_mem [16];

   periph_amo_target #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .BYTE_ENABLE_BIT(4),
      .NUM_WORDS(16),
      .BASE_ADDR(BASE)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .data_req_i(req),
      .data_add_i(add),
      .data_wen_i(wen),
      .data_atop_i(atop),
      .data_wdata_i(wdata),
      .data_be_i(be),
      .data_gnt_o(gnt),
      .data_r_valid_o(r_valid),
      .data_r_opc_o(r_opc),
      .data_r_rdata_o(r_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit fn_valid(input logic [4:0] fn);
      logic [4:0] ok [9] = '{5'h00, 5'h01, 5'h04, 5'h0C, 5'h08,
                             5'h10, 5'h14, 5'h18, 5'h1C};
      foreach (ok[k]) if (ok[k] == fn) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] amo_ref(input logic [4:0] fn,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      case (fn)
         5'h00: return a + b;
         5'h01: return b;
         5'h04: return a ^ b;
         5'h0C: return a & b;
         5'h08: return a | b;
         5'h10: return (sa <= sb) ? a : b;
         5'h14: return (sa >= sb) ? a : b;
         5'h18: return (a <= b) ? a : b;
         5'h1C: return (a >= b) ? a : b;
         default: return a;
      endcase
   endfunction

   task automatic idle_bus();
      req   = 1'b0;
      add   = '0;
      wen   = 1'b1;
      atop  = '0;
      wdata = '0;
      be    = '0;
   endtask

   // Starts at posedge+1; ends at posedge+1 so calls run back to back.
   task automatic do_op(input logic amo, input logic [4:0] fn,
                        input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] bmask);
      logic [31:0] off;
      logic        hit;
      logic        bad;
      int          i;
      off = a - BASE;
      hit = off < 32'd64;
      i   = int'(off[5:2]);
      bad = !hit || (amo && (!fn_valid(fn) || bmask != 4'hF));
      req   = 1'b1;
      add   = a;
      wen   = w;
      atop  = {amo, fn};
      wdata = d;
      be    = bmask;
      #1;
      chk("gnt", 32'(gnt), 32'd1);
      @(posedge clk);
      #1;
      idle_bus();
      chk("r_valid", 32'(r_valid), 32'd1);
      if (bad) begin
         chk("err_opc", 32'(r_opc), 32'd1);
         chk("err_rdata", r_rdata, 32'd0);
      end else if (amo) begin
         chk("amo_opc", 32'(r_opc), 32'd0);
         chk("amo_old", r_rdata, ref_mem[i]);
         // Hold a read pending through the write-back slot.
         req  = 1'b1;
         add  = a;
         wen  = 1'b1;
         #1;
         chk("amo_wb_gnt", 32'(gnt), 32'd0);
         @(posedge clk);
         #1;
         idle_bus();
         chk("amo_wb_rvalid", 32'(r_valid), 32'd0);
         ref_mem[i] = amo_ref(fn, ref_mem[i], d);
      end else if (w) begin
         chk("rd_opc", 32'(r_opc), 32'd0);
         chk("rd_data", r_rdata, ref_mem[i]);
      end else begin
         chk("wr_opc", 32'(r_opc), 32'd0);
         chk("wr_rdata", r_rdata, 32'd0);
         for (int b = 0; b < 4; b++) begin
            if (bmask[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   task automatic rd(input logic [31:0] a);
      do_op(1'b0, 5'h0, 1'b1, a, 32'h0, 4'hF);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] bmask);
      do_op(1'b0, 5'h0, 1'b0, a, d, bmask);
   endtask

   task automatic amo_op(input logic [4:0] fn, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] bmask);
      do_op(1'b1, fn, 1'b1, a, d, bmask);
   endtask

   initial begin
      logic [4:0]  good [9] = '{5'h00, 5'h01, 5'h04, 5'h0C, 5'h08,
                                5'h10, 5'h14, 5'h18, 5'h1C};
      logic [4:0]  fn;
      logic [31:0] a;
      logic [3:0]  bm;
      int          kind;
      nchk = 0;
      nerr = 0;
      foreach (ref_mem[k]) ref_mem[k] = '0;
      idle_bus();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rvalid", 32'(r_valid), 32'd0);
      chk("rst_opc", 32'(r_opc), 32'd0);
      chk("rst_rdata", r_rdata, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      wr(BASE + 32'h4, 32'hDEADBEEF, 4'hF);
      rd(BASE + 32'h4);
      chk("dir_deadbeef", ref_mem[1], 32'hDEADBEEF);
      wr(BASE + 32'h8, 32'h11223344, 4'hF);
      wr(BASE + 32'h8, 32'h000000AA, 4'b0001);
      rd(BASE + 32'h8);
      chk("dir_be", ref_mem[2], 32'h112233AA);
      wr(BASE + 32'hC, 32'hFFFFFFFE, 4'hF);
      amo_op(5'h00, BASE + 32'hC, 32'd5, 4'hF);
      rd(BASE + 32'hC);
      chk("dir_add", ref_mem[3], 32'h3);
      wr(BASE + 32'h10, 32'h80000000, 4'hF);
      amo_op(5'h14, BASE + 32'h10, 32'd1, 4'hF);
      rd(BASE + 32'h10);
      wr(BASE + 32'h14, 32'h80000000, 4'hF);
      amo_op(5'h1C, BASE + 32'h14, 32'd1, 4'hF);
      rd(BASE + 32'h14);
      rd(BASE + 32'd64);
      amo_op(5'h00, BASE + 32'h4, 32'd7, 4'b0011);
      amo_op(5'h02, BASE + 32'h4, 32'd7, 4'hF);
      amo_op(5'h03, BASE + 32'h4, 32'd7, 4'hF);
      rd(BASE + 32'h4);
      wr(BASE + 32'h4, 32'h12345678, 4'h0);
      rd(BASE + 32'h4);
      rd(BASE - 32'd4);

      for (int n = 0; n < 400; n++) begin
         kind = int'($urandom_range(0, 9));
         if ($urandom_range(0, 9) < 8) a = BASE + $urandom_range(0, 63);
         else if ($urandom_range(0, 1) == 1)
            a = BASE + 32'd64 + $urandom_range(0, 255);
         else a = BASE - 32'd1 - $urandom_range(0, 15);
         if ($urandom_range(0, 9) < 8) fn = good[$urandom_range(0, 8)];
         else fn = 5'($urandom);
         bm = ($urandom_range(0, 9) < 8) ? 4'hF : 4'($urandom);
         if (kind < 3) rd(a);
         else if (kind < 6) wr(a, $urandom, 4'($urandom));
         else amo_op(fn, a, $urandom, bm);
      end

      // Continuous R, W, AMO stream with reset during the write-back slot.
      rd(BASE + 32'h4);
      wr(BASE + 32'h8, 32'hCAFEF00D, 4'hF);
      req   = 1'b1;
      add   = BASE + 32'h8;
      wen   = 1'b1;
      atop  = 6'b100000;
      wdata = 32'd1;
      be    = 4'hF;
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle_bus();
      #1;
      chk("mid_rst_rvalid", 32'(r_valid), 32'd0);
      chk("mid_rst_opc", 32'(r_opc), 32'd0);
      chk("mid_rst_rdata", r_rdata, 32'd0);
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      @(posedge clk);
      #1;
      chk("mid_rst_hold", 32'(r_valid), 32'd0);
      rst = 1'b0;
      foreach (ref_mem[k]) ref_mem[k] = '0;
      @(posedge clk);
      #1;
      chk("post_rst_rvalid", 32'(r_valid), 32'd0);
      for (int k = 0; k < 16; k++) rd(BASE + 32'(4 * k));

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
